// File: rtl/dct_coef_mac.sv
// dct_coef_mac: single-coefficient 2-D DCT multiply-accumulate over an 8x8 block.
// Buffers 64 unsigned pixels and walks them against an external cosine LUT.
// Each product is accumulated as (pixel-128) * cos_term. The sum is then
// arithmetically shifted right by FRAC and presented on a valid/ready output.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   pix_valid/ready   pixel input handshake; pix_data is an unsigned 8-bit pixel, row-major
//   n1, n2            row/column index to the cosine LUT (0 outside CALC)
//   cos_term          signed LUT value for (n1,n2), combinational in the same cycle
//   coef/valid/ready  signed coefficient output handshake
module dct_coef_mac #(
  parameter int unsigned FRAC  = 8,
  parameter int unsigned ACC_W = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_valid,
  input  logic [7:0]         pix_data,
  output logic               pix_ready,
  output logic [2:0]         n1,
  output logic [2:0]         n2,
  input  logic signed [31:0] cos_term,
  output logic signed [31:0] coef,
  output logic               coef_valid,
  input  logic               coef_ready
);

  localparam int unsigned IDX_W  = 6;
  localparam int unsigned PIX_N  = 64;
  localparam int unsigned COEF_W = 32;

  typedef enum logic [1:0] {LOAD, CALC, OUT} state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [COEF_W-1:0]  coef_q, coef_d;
  logic                      coef_valid_q, coef_valid_d;

  logic [7:0]                buf_q [PIX_N];
  logic                      buf_we;

  logic signed [8:0]         pix_diff;
  logic signed [ACC_W-1:0]   prod;
  logic signed [ACC_W-1:0]   acc_sum;

  // Datapath: centred pixel times LUT term, both sign-extended to ACC_W
  always_comb begin
    pix_diff = $signed({1'b0, buf_q[idx_q]}) - 9'sd128;
    prod     = ACC_W'(pix_diff) * ACC_W'(cos_term);
    acc_sum  = acc_q + prod;
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    coef_d       = coef_q;
    coef_valid_d = coef_valid_q;
    buf_we       = 1'b0;
    pix_ready    = 1'b0;
    n1           = 3'd0;
    n2           = 3'd0;
    case (state_q)
      LOAD: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          buf_we = 1'b1;
          idx_d  = idx_q + 6'd1;
          if (idx_q == 6'd63) begin
            state_d = CALC;
            acc_d   = '0;
          end
        end
      end
      CALC: begin
        n1    = idx_q[5:3];
        n2    = idx_q[2:0];
        acc_d = acc_sum;
        idx_d = idx_q + 6'd1;
        if (idx_q == 6'd63) begin
          // Floor division by 2^FRAC, then keep the low 32 bits
          coef_d       = COEF_W'(acc_sum >>> FRAC);
          coef_valid_d = 1'b1;
          state_d      = OUT;
        end
      end
      OUT: begin
        if (coef_ready) begin
          state_d      = LOAD;
          idx_d        = '0;
          coef_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      idx_q        <= '0;
      acc_q        <= '0;
      coef_q       <= '0;
      coef_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      coef_q       <= coef_d;
      coef_valid_q <= coef_valid_d;
    end
  end

  // Pixel buffer is not reset; a new block always overwrites from index 0
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[idx_q] <= pix_data;
    end
  end

  assign coef       = coef_q;
  assign coef_valid = coef_valid_q;

endmodule

// File: tb/tb_dct_coef_mac.sv
// tb_dct_coef_mac: table-driven directed bench for dct_coef_mac.
// Each vector sends one block: pixel 0 is p0 and all other pixels are po.
// The LUT entry for index 0 is l0 and all other entries are lo.
// Expected coefficients are hand computed.
module tb_dct_coef_mac;

  logic               clk;
  logic               rst;
  logic               pix_valid;
  logic [7:0]         pix_data;
  logic               pix_ready;
  logic [2:0]         n1;
  logic [2:0]         n2;
  logic signed [31:0] cos_term;
  logic [31:0]        coef;
  logic               coef_valid;
  logic               coef_ready;

  logic signed [31:0] lut [64];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  p0;
    logic [7:0]  po;
    logic [31:0] l0;
    logic [31:0] lo;
    bit          gaps;
    int          hold;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  dct_coef_mac #(.FRAC(8), .ACC_W(40)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .n1         (n1),
    .n2         (n2),
    .cos_term   (cos_term),
    .coef       (coef),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready)
  );

  assign cos_term = lut[{n1, n2}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_lut(input logic [31:0] l0, input logic [31:0] lo);
    for (int i = 0; i < 64; i++) lut[i] = (i == 0) ? l0 : lo;
  endtask

  // Called at a negedge; returns at the negedge right after the last transfer edge
  task automatic send_block(input logic [7:0] p0, input logic [7:0] po,
                            input bit gaps, input int n, input string name);
    int  i = 0;
    int  guard = 0;
    bit  rdy_ok = 1'b1;
    bit  idx_ok = 1'b1;
    while (i < n && guard < 2000) begin
      if (n1 !== 3'd0 || n2 !== 3'd0) idx_ok = 1'b0;
      if (gaps && $urandom_range(0, 2) == 0) begin
        pix_valid = 1'b0;
        pix_data  = 8'($urandom);
      end else begin
        pix_valid = 1'b1;
        pix_data  = (i == 0) ? p0 : po;
        if (pix_ready === 1'b1) i++;
        else rdy_ok = 1'b0;
      end
      guard++;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    chk({name, " load_done"}, 32'(i), 32'(n));
    chk({name, " pix_ready_load"}, 32'(rdy_ok), 32'd1);
    chk({name, " n_idx_load"}, 32'(idx_ok), 32'd1);
  endtask

  // Counts edges from the last transfer to coef_valid, then holds and handshakes
  task automatic wait_result(input logic [31:0] exp, input int hold, input string name);
    int cnt = 0;
    bit rdy_ok = 1'b1;
    bit hold_ok = 1'b1;
    while (coef_valid !== 1'b1 && cnt < 200) begin
      if (pix_ready !== 1'b0) rdy_ok = 1'b0;
      pix_valid = 1'($urandom_range(0, 1));
      pix_data  = 8'($urandom);
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    chk({name, " latency"}, 32'(cnt), 32'd64);
    chk({name, " coef"}, coef, exp);
    for (int h = 0; h < hold; h++) begin
      if (pix_ready !== 1'b0 || coef_valid !== 1'b1 || coef !== exp) hold_ok = 1'b0;
      pix_valid = 1'($urandom_range(0, 1));
      pix_data  = 8'($urandom);
      @(negedge clk);
    end
    if (pix_ready !== 1'b0) rdy_ok = 1'b0;
    chk({name, " pix_ready_busy"}, 32'(rdy_ok), 32'd1);
    if (hold > 0) chk({name, " out_hold"}, 32'(hold_ok), 32'd1);
    pix_valid  = 1'b0;
    coef_ready = 1'b1;
    @(negedge clk);
    coef_ready = 1'b0;
    chk({name, " valid_drop"}, 32'(coef_valid), 32'd0);
    chk({name, " ready_back"}, 32'(pix_ready), 32'd1);
    chk({name, " coef_kept"}, coef, exp);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    set_lut(v.l0, v.lo);
    send_block(v.p0, v.po, v.gaps, 64, name);
    wait_result(v.exp, v.hold, name);
  endtask

  task automatic pulse_rst(input string name);
    rst = 1'b1;
    @(negedge clk);
    chk({name, " coef_rst"}, coef, 32'd0);
    chk({name, " valid_rst"}, 32'(coef_valid), 32'd0);
    chk({name, " n_rst"}, {26'd0, n1, n2}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk({name, " ready_rst"}, 32'(pix_ready), 32'd1);
  endtask

  initial begin
    //          p0     po     l0            lo            gaps hold exp
    vecs[0] = '{8'd128, 8'd128, 32'h0000002e, 32'hffffff4f, 1'b0, 0,  32'h00000000};
    vecs[1] = '{8'd255, 8'd128, 32'h0000002e, 32'h0000007f, 1'b0, 0,  32'h00000016};
    vecs[2] = '{8'd0,   8'd128, 32'h0000002e, 32'h0000007f, 1'b0, 0,  32'hffffffe9};
    vecs[3] = '{8'd129, 8'd129, 32'h00000100, 32'h00000100, 1'b0, 0,  32'h00000040};
    vecs[4] = '{8'd127, 8'd127, 32'h00000003, 32'h00000003, 1'b0, 0,  32'hffffffff};
    vecs[5] = '{8'd255, 8'd255, 32'h00010000, 32'h00010000, 1'b0, 10, 32'h001fc000};
    vecs[6] = '{8'd0,   8'd0,   32'hffff0000, 32'hffff0000, 1'b0, 0,  32'h00200000};
    vecs[7] = '{8'd255, 8'd255, 32'h01000000, 32'h01000000, 1'b0, 0,  32'h1fc00000};
    vecs[8] = '{8'd200, 8'd100, 32'hfffffff6, 32'h00000002, 1'b0, 0,  32'hffffffef};
    vecs[9] = '{8'd200, 8'd100, 32'hfffffff6, 32'h00000002, 1'b1, 3,  32'hffffffef};

    rst        = 1'b1;
    pix_valid  = 1'b0;
    pix_data   = 8'd0;
    coef_ready = 1'b0;
    set_lut(32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("reset coef", coef, 32'd0);
    chk("reset valid", 32'(coef_valid), 32'd0);
    chk("reset n", {26'd0, n1, n2}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset ready", 32'(pix_ready), 32'd1);

    // Blocks run back to back: each starts the cycle after the previous handshake
    for (int k = 0; k < 10; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Reset in the middle of LOAD: the partial block must be discarded
    set_lut(32'h0000002e, 32'h0000007f);
    send_block(8'd0, 8'd0, 1'b0, 20, "partial");
    pulse_rst("rst_load");
    run_vec(vecs[1], "after_rst_load");

    // Reset in CALC at idx 30, with an all-zero block in flight
    set_lut(32'h0000002e, 32'h0000007f);
    send_block(8'd0, 8'd0, 1'b0, 64, "aborted");
    repeat (30) @(negedge clk);
    pulse_rst("rst_calc");
    run_vec(vecs[1], "after_rst_calc");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
